// File: rtl/blink64a_pkg.sv
// Shared constants and helpers for the Blink-64a round-key generator.
package blink64a_pkg;

  localparam int         BLINK_KEY_W   = 128;
  localparam int         BLINK_RK_W    = 64;
  localparam int         BLINK_ROUNDS  = 16;
  localparam logic [5:0] BLINK_RC_SEED = 6'h01;
  localparam int         BLINK_KROT    = 13;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Left-rotate of the upper key half by the fixed schedule amount.
  function automatic logic [63:0] rotl_krot(input logic [63:0] x);
    return {x[63-BLINK_KROT:0], x[63:64-BLINK_KROT]};
  endfunction

  // One step of the 6-bit round-constant LFSR (x^6 + x^5 + 1, never reaches zero).
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4]};
  endfunction

endpackage

// File: rtl/blink64a_rc_lfsr.sv
// Round-constant LFSR; a load restarts the sequence and wins over a step.
module blink64a_rc_lfsr
  import blink64a_pkg::*;
#(
  parameter logic [5:0] SEED = BLINK_RC_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [5:0] rc
);

  // Hold, reseed or advance the round constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= SEED;
    end else if (load) begin
      rc <= SEED;
    end else if (step) begin
      rc <= rc_next(rc);
    end
  end

endmodule

// File: rtl/blink64a_round_key_gen.sv
// Iterative round-key generator: loads a master key, then streams ROUNDS
// round keys over a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for a master key, key_ready high
//   ST_RUN  | presenting round keys, rk_valid high
module blink64a_round_key_gen
  import blink64a_pkg::*;
#(
  parameter int         KEY_W   = BLINK_KEY_W,
  parameter int         RK_W    = BLINK_RK_W,
  parameter int         ROUNDS  = BLINK_ROUNDS,
  parameter logic [5:0] RC_SEED = BLINK_RC_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] master_key,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk,
  output logic [4:0]       rk_round,
  output logic             rk_last,
  output logic             busy
);

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS - 1);

  logic             state;
  logic [KEY_W-1:0] k;
  logic [4:0]       cnt;
  logic [5:0]       rc;
  logic             accept;
  logic             hs;
  logic             at_last;

  assign key_ready = (state == ST_IDLE);
  assign rk_valid  = (state == ST_RUN);
  assign busy      = rk_valid;
  assign accept    = key_valid && key_ready;
  assign hs        = rk_valid && rk_ready;
  assign at_last   = (cnt == LAST_CNT);

  // The constant freezes on the final handshake, same as the key register.
  blink64a_rc_lfsr #(.SEED(RC_SEED)) u_rc_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (hs && !at_last),
    .rc   (rc)
  );

  // Outputs are forced to zero outside RUN so idle/reset values are clean.
  assign rk       = rk_valid ? (k[KEY_W-1:RK_W] ^ {{(RK_W-6){1'b0}}, rc}) : '0;
  assign rk_round = rk_valid ? cnt : 5'd0;
  assign rk_last  = rk_valid && at_last;

  // FSM, key schedule register and round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      cnt   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            k     <= master_key;
            cnt   <= 5'd0;
            state <= ST_RUN;
          end
        end
        default: begin
          if (rk_ready) begin
            if (at_last) begin
              state <= ST_IDLE;
            end else begin
              k   <= {k[RK_W-1:0], rotl_krot(k[KEY_W-1:RK_W]) ^ k[RK_W-1:0]};
              cnt <= cnt + 5'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink64a_round_key_gen.sv
// Directed bench for blink64a_round_key_gen with a small key-schedule model.
module tb_blink64a_round_key_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] master_key = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [63:0]  rk;
  logic [4:0]   rk_round;
  logic         rk_last;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [127:0] m_k;
  logic [5:0]   m_rc;
  logic [63:0]  rk_seen [16];

  always #5 clk = ~clk;

  blink64a_round_key_gen dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .master_key (master_key),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk         (rk),
    .rk_round   (rk_round),
    .rk_last    (rk_last),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl13(input logic [63:0] x);
    return (x << 13) | (x >> 51);
  endfunction

  task automatic model_load(input logic [127:0] key);
    m_k  = key;
    m_rc = 6'h01;
  endtask

  task automatic model_step();
    m_k  = {m_k[63:0], rotl13(m_k[127:64]) ^ m_k[63:0]};
    m_rc = {m_rc[4:0], m_rc[5] ^ m_rc[4]};
  endtask

  // Drive a key at a negedge; the next negedge is the first RUN cycle.
  task automatic load_key(input logic [127:0] key);
    key_valid  = 1'b1;
    master_key = key;
    @(negedge clk);
    key_valid = 1'b0;
    model_load(key);
  endtask

  // Consume beats starting in RUN. bp_at: stall 5 cycles at that round.
  // kv_at: pulse key_valid with another key. rst_at: reset and stop there.
  task automatic stream(input string nm, input int bp_at, input int kv_at, input int rst_at);
    logic [63:0] hold_rk;
    for (int r = 0; r < 16; r++) begin
      check($sformatf("%s r%0d rk_valid", nm, r), 64'(rk_valid), 64'd1);
      check($sformatf("%s r%0d rk", nm, r), rk, m_k[127:64] ^ {58'd0, m_rc});
      check($sformatf("%s r%0d rk_round", nm, r), 64'(rk_round), 64'(r));
      check($sformatf("%s r%0d rk_last", nm, r), 64'(rk_last), 64'(r == 15));
      check($sformatf("%s r%0d key_ready", nm, r), 64'(key_ready), 64'd0);
      check($sformatf("%s r%0d busy", nm, r), 64'(busy), 64'd1);
      rk_seen[r] = rk;
      if (r == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({nm, " post-rst rk_valid"}, 64'(rk_valid), 64'd0);
        check({nm, " post-rst rk"}, rk, 64'd0);
        check({nm, " post-rst key_ready"}, 64'(key_ready), 64'd1);
        check({nm, " post-rst rk_round"}, 64'(rk_round), 64'd0);
        return;
      end
      if (r == bp_at) begin
        hold_rk  = m_k[127:64] ^ {58'd0, m_rc};
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check($sformatf("%s bp%0d rk", nm, c), rk, hold_rk);
          check($sformatf("%s bp%0d rk_round", nm, c), 64'(rk_round), 64'(r));
          check($sformatf("%s bp%0d rk_last", nm, c), 64'(rk_last), 64'd0);
          check($sformatf("%s bp%0d rk_valid", nm, c), 64'(rk_valid), 64'd1);
        end
        rk_ready = 1'b1;
      end
      if (r == kv_at) begin
        key_valid  = 1'b1;
        master_key = ~master_key;
      end
      @(negedge clk);
      if (r == kv_at) begin
        check({nm, " kv-ignored key_ready"}, 64'(key_ready), 64'd0);
        key_valid = 1'b0;
      end
      if (r < 15) model_step();
    end
    check({nm, " end rk_valid"}, 64'(rk_valid), 64'd0);
    check({nm, " end key_ready"}, 64'(key_ready), 64'd1);
    check({nm, " end busy"}, 64'(busy), 64'd0);
    check({nm, " end rk"}, rk, 64'd0);
  endtask

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    logic [63:0]  exp1 [6];
    exp1[0] = 64'h01; exp1[1] = 64'h02; exp1[2] = 64'h04;
    exp1[3] = 64'h08; exp1[4] = 64'h10; exp1[5] = 64'h21;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset key_ready", 64'(key_ready), 64'd1);
    check("reset rk_valid", 64'(rk_valid), 64'd0);
    check("reset rk", rk, 64'd0);
    check("reset rk_round", 64'(rk_round), 64'd0);
    check("reset rk_last", 64'(rk_last), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero key, hand-computed constants
    load_key('0);
    stream("zero", -1, -1, -1);
    for (int i = 0; i < 6; i++) check($sformatf("zero const r%0d", i), rk_seen[i], exp1[i]);

    // 2: upper half all ones
    load_key({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    check("ones rk0", rk, 64'hFFFF_FFFF_FFFF_FFFE);
    stream("ones", -1, -1, -1);
    check("ones rk1", rk_seen[1], 64'h0000_0000_0000_0002);

    // 3: backpressure at round 3
    load_key(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    stream("bp", 3, -1, -1);

    // 4: stray key_valid during RUN, stream must match scenario 1
    load_key('0);
    stream("kv", -1, 4, -1);
    for (int i = 0; i < 6; i++) check($sformatf("kv const r%0d", i), rk_seen[i], exp1[i]);

    // 5: reset during round 7, then reload
    load_key(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    stream("rst", -1, -1, 7);
    load_key(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    check("reload rk0", rk, 64'hDEAD_BEEF_0000_1111 ^ 64'h01);
    stream("reload", -1, -1, -1);

    // 6: back-to-back random keys, key_valid held high
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    key_valid  = 1'b1;
    master_key = k1;
    @(negedge clk);
    model_load(k1);
    master_key = k2;
    stream("b2b-a", -1, -1, -1);
    @(negedge clk);
    key_valid = 1'b0;
    model_load(k2);
    check("b2b-b rk0", rk, k2[127:64] ^ 64'h01);
    stream("b2b-b", -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
